col7_line_buffer: RTL
=====================

Name: col7_line_buffer

Overview:
- Producer side of the 7-pixel column interface consumed by the orientation unit.
- Converts a raster-order 8-bit grayscale pixel stream into vertical 7-pixel columns, one column per accepted pixel, ordered top row to bottom row.
- Buffers the previous 6 image rows in rotating line memories; output is suppressed until 7 rows are available.
- Sits between the pixel-input/FAST front end and the orientation unit; its o_col/o_valid drive that unit's i_col0/i_valid directly.

Parameters:
- WIDTH, 640, pixels per image row (line memory depth).
- HEIGHT, 480, rows per frame (row counter wrap point).
- XW, 10, width of column coordinate (ceil log2 WIDTH).
- YW, 9, width of row coordinate (ceil log2 HEIGHT).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_pixel  input  8  incoming pixel, raster order.
- i_valid  input  1  i_pixel is valid this cycle. There is no backpressure.
- i_sof  input  1  start of frame; qualified by i_valid; marks i_pixel as (x=0, y=0).
- o_col  output  56  column; byte k (bits k*8+7:k*8) = pixel at row y-6+k, same x. Byte 0 is the top row, byte 6 is the current pixel.
- o_valid  output  1  o_col is valid.
- o_x  output  XW  column index of o_col.
- o_y  output  YW  center row of o_col (y-3).

Behaviour:
- Reset (async, i_rst_n=0):
  - x_cnt, y_cnt, row pointer = 0.
  - o_col = 0, o_valid = 0, o_x = 0, o_y = 0.
  - Line memory contents are not reset. Outputs are gated, so their contents are don't-care.
- Counters: for each cycle with i_valid=1:
  - If i_sof=1, the pixel is taken as (0,0).
  - Otherwise the pixel is at the current (x_cnt, y_cnt).
  - After the pixel: x_cnt increments. At x_cnt=WIDTH-1 it wraps to 0, y_cnt increments, and the row pointer advances mod 6.
  - At y_cnt=HEIGHT-1 with a row wrap, y_cnt wraps to 0 (implicit next frame).
- Line memories:
  - 6 physical memories, each WIDTH x 8, each 1R1W.
  - The logical row r (1..6 rows above current) maps to physical index (rowptr + 6 - r) mod 6.
  - On an accepted pixel, all 6 memories are read at x; the pixel is written into the memory holding row y-6, the oldest row.
  - Read-during-write to the same address returns old data.
- Output, registered, latency 1 cycle from the accepted pixel:
  - o_col = {pixel, row y-1, ..., row y-6}.
  - o_x = x.
  - o_y = y-3.
  - o_valid = 1 only if y >= 6.
- Stall: if i_valid=0, counters, pointer and memories are held, and o_valid=0 on the next cycle. o_col, o_x and o_y hold their last values.
- i_sof mid-frame:
  - Counters restart at that pixel and the row pointer is unchanged.
  - The rows already in the memories are treated as stale: o_valid stays 0 until y=6 of the new frame.
- i_sof with i_valid=0 is ignored.
- No underflow or overflow conditions exist. Every accepted pixel produces exactly one output cycle (valid or not).
- Per-frame o_valid count = WIDTH*(HEIGHT-6).

Decomposition:
- Shared package ov_pkg:
  - pixel_t (8-bit).
  - col7_t (56-bit packed array of 7 pixel_t).
  - Constants IMG_WIDTH=640, IMG_HEIGHT=480, PATCH=7.
- One sub-module, line_mem:
  - WIDTH x 8, 1R1W, asynchronous read, synchronous write with write enable.
  - Old-data-on-collision read.
  - Instantiated 6 times.
- Counters, row-pointer mapping and output register live in the top module.

Test Plan:
All tests use WIDTH=8, HEIGHT=10, pixel value = (16*y+x) mod 256.
1. Reset, then a continuous frame with i_sof on the first pixel:
   - First o_valid appears the cycle after pixel (0,6), with o_col = 0x60504030201000, o_x=0, o_y=3.
   - Last o_valid: o_col = 0x97877767574737, o_x=7, o_y=6.
   - Exactly 32 o_valid cycles in the frame.
2. Same frame with i_valid toggled randomly at 50%:
   - The o_valid sequence and o_col values are identical to test 1.
   - o_valid never asserts on a cycle following i_valid=0.
3. Two back-to-back frames without a second i_sof, second frame pixels = value + 0x80:
   - Frame 2 produces no o_valid until y=6.
   - Frame 2's first output is 0xE0D0C0B0A09080.
4. i_sof asserted at pixel (3,7) of a frame:
   - o_valid is 0 for the next 48 accepted pixels.
   - It then resumes with o_x=0, o_y=3 and the new-frame data.
5. Assert i_rst_n=0 for 1 cycle at pixel (5,8):
   - o_valid, o_col, o_x and o_y are 0 immediately (asynchronously).
   - After a restart with i_sof, test 1's expectations hold.
6. Read/write collision check:
   - At pixel (x,6), the row-0 value at x (16*0+x) appears in byte 0 of o_col.
   - The memory at that address then holds 0x60+x, confirmed by the row-7 output's byte 5.

Source files
------------

// File: rtl/ov_pkg.sv
// Shared types and image constants for the orientation datapath.
// Includes the ring-index helper that maps a line-buffer row to its physical memory.
package ov_pkg;

    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;
    localparam int PATCH      = 7;
    localparam int NROWS      = PATCH - 1;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [PATCH-1:0] col7_t;

    // Physical memory index of (base + k) mod NROWS, for k in 0..NROWS-1.
    function automatic logic [2:0] ring_idx(input logic [2:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NROWS) s = s - NROWS;
        return s[2:0];
    endfunction

endpackage

// File: rtl/line_mem.sv
// One row of pixel storage: asynchronous read, synchronous write.
// A read to the address being written in the same cycle returns the old data.
module line_mem
    import ov_pkg::*;
#(
    parameter int WIDTH = IMG_WIDTH,
    parameter int XW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [XW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [XW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    pixel_t mem [WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/col7_line_buffer.sv
// Raster pixel stream to 7-pixel vertical columns using six rotating line memories.
// Output columns are valid once six earlier rows of the current frame are stored.
module col7_line_buffer
    import ov_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int XW     = 10,
    parameter int YW     = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_pixel,
    input  logic          i_valid,
    input  logic          i_sof,
    output logic [55:0]   o_col,
    output logic          o_valid,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
);

    localparam int CENTER = PATCH / 2;

    logic [XW-1:0] x_cnt, x_cur, x_p1;
    logic [YW-1:0] y_cnt, y_cur, y_p1;
    logic [2:0]    rowptr;
    pixel_t        rd_data [NROWS];
    col7_t         col_p0, col_p1;
    logic          vld_p1;

    // A start-of-frame pixel is taken as (0,0) regardless of the counters.
    assign x_cur = i_sof ? '0 : x_cnt;
    assign y_cur = i_sof ? '0 : y_cnt;

    for (genvar g = 0; g < NROWS; g++) begin : g_mem
        line_mem #(.WIDTH(WIDTH), .XW(XW)) u_mem (
            .i_clk   (i_clk),
            .i_we    (i_valid && (rowptr == 3'(g))),
            .i_waddr (x_cur),
            .i_wdata (i_pixel),
            .i_raddr (x_cur),
            .o_rdata (rd_data[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            rowptr <= '0;
        end else if (i_valid) begin
            if (x_cur == XW'(WIDTH - 1)) begin
                x_cnt  <= '0;
                y_cnt  <= (y_cur == YW'(HEIGHT - 1)) ? '0 : y_cur + 1'b1;
                rowptr <= (rowptr == 3'(NROWS - 1)) ? '0 : rowptr + 1'b1;
            end else begin
                x_cnt  <= x_cur + 1'b1;
                y_cnt  <= y_cur;
            end
        end
    end

    // Stage p0: byte k is row y-6+k, held in physical memory (rowptr + k) mod 6.
    always_comb begin
        col_p0 = '0;
        for (int k = 0; k < NROWS; k++) begin
            col_p0[k] = rd_data[ring_idx(rowptr, k)];
        end
        col_p0[PATCH-1] = i_pixel;
    end

    // Stage p1: registered column and coordinates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            col_p1 <= '0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else begin
            vld_p1 <= i_valid && (y_cur >= YW'(NROWS));
            if (i_valid) begin
                col_p1 <= col_p0;
                x_p1   <= x_cur;
                y_p1   <= y_cur - YW'(CENTER);
            end
        end
    end

    assign o_col   = col_p1;
    assign o_valid = vld_p1;
    assign o_x     = x_p1;
    assign o_y     = y_p1;

endmodule
